sccb_master: RTL and testbench
==============================

# sccb_master

Parametrised SCCB/I2C-style master for camera register access. It is the successor to the write-only camera configuration interface and adds register reads, 1- or 2-byte sub-addresses, a configurable device address, and optional ACK checking. It sits between the camera init ROM/sequencer and the open-drain SIOC/SIOD pads.

## Interface
- CLK_FREQ, 25000000: clk frequency in Hz.
- SCCB_FREQ, 100000: SCL bit rate in Hz. Q = CLK_FREQ/(4*SCCB_FREQ) (integer division) is the quarter-bit period in clk cycles; Q ≥ 2 required.
- DEV_ADDR, 8'h42: 8-bit write address; the read address is DEV_ADDR|1.
- ADDR_BYTES, 1: sub-address length, 1 or 2; 2 sends addr[15:8] first.
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request; accepted only on a cycle with ready=1.
- rw  in  1  0=write, 1=read; latched at accept.
- addr  in  16  register sub-address; latched at accept. Only [7:0] is used when ADDR_BYTES=1.
- wdata  in  8  write data; latched at accept.
- SIOD_in  in  1  asynchronous pad readback of SIOD.
- ready  out  1  idle; able to accept start.
- rdata  out  8  read result; holds until the next read completes.
- rdata_valid  out  1  one-cycle pulse at read completion.
- nack  out  1  ACK failure flag; cleared on accept.
- SIOC_oe  out  1  1 drives SIOC low, 0 releases it (high).
- SIOD_oe  out  1  1 drives SIOD low, 0 releases it (high).

## Operation
- Reset values:
  - ready=1, SIOC_oe=0, SIOD_oe=0, rdata=0, rdata_valid=0, nack=0.
  - FSM returns to IDLE.
- Reset mid-transfer releases both lines on the next edge. No stop condition is generated.
- start while ready=0 is ignored.
- States: IDLE, START, BIT_LO, BIT_SET, BIT_HI, NEXT, STOP_1..STOP_4, GAP. The timed states (START, BIT_LO, BIT_SET, BIT_HI, STOP_1..STOP_4, GAP) hold for a fixed number of Q periods; NEXT is the zero-time byte/bit advance and is merged into the preceding state's final cycle.
- Bit timing (4Q per bit):
  - BIT_LO (Q): SIOC_oe=1.
  - BIT_SET (Q): SIOD_oe = ~bit.
  - BIT_HI (2Q): SIOC_oe=0.
  - 9th bit of each byte: SIOD_oe=0, the ACK slot.
- START (Q): SIOD_oe=1 with SIOC released.
- Stop condition, Q each:
  - STOP_1: SIOC_oe=1.
  - STOP_2: SIOD_oe=1.
  - STOP_3: SIOC_oe=0.
  - STOP_4: SIOD_oe=0.
- Write sequence: START, DEV_ADDR, sub-address byte(s), wdata, stop, GAP (8Q), then IDLE.
- Read sequence:
  - Phase 1: START, DEV_ADDR, sub-address byte(s), stop, 2Q bus-free gap.
  - Phase 2: START, DEV_ADDR|1, 8 bits received with SIOD_oe=0, master NACK on the 9th bit (SIOD_oe=0), stop, GAP (8Q).
- Sampling:
  - SIOD_in passes through a 2-flop synchroniser.
  - Received bits and ACK bits are sampled on the last clk of BIT_HI.
  - Received bits shift MSB-first into the shift register.
- Completion: rdata loads from the shift register at the last GAP cycle. ready and rdata_valid (reads only) assert on the cycle after that.
- Counters:
  - Quarter timer width is $clog2(8*Q+1). It down-counts and wraps to reload.
  - Bit index is 4 bits, 0..8.
  - Byte index is 2 bits.

## Timing
- From the accept edge: SIOD_oe=1 on the next cycle; ready=0 on the next cycle.
- Each transmitted byte costs 36Q cycles.
- Write transfer duration, from accept to ready=1: (121+36*(ADDR_BYTES-1))*Q cycles. Default parameters: 7502 cycles.
- Read transfer duration: (164+36*(ADDR_BYTES-1))*Q cycles.
- nack behaviour (only with ACK check compiled in):
  - An ACK sampled high during a master-transmitted byte sets nack.
  - The FSM then jumps to STOP_1 and finishes STOP, GAP, IDLE.
  - rdata_valid stays 0 and rdata is unchanged.

## Configuration
- SCCB_NACK_CHECK_EN defined:
  - ACK slots are checked.
  - NACK aborts as described under Timing.
- SCCB_NACK_CHECK_EN undefined:
  - ACK slots are don't-care, matching SCCB.
  - nack is tied to 0.
  - Transfers always run to full length.
- SIOD_in remains in use in both configurations for read data.

## Structure
- Package sccb_pkg holds:
  - the FSM state enum;
  - the phase-length constants (START=1, BIT_LO=1, BIT_SET=1, BIT_HI=2, STOP_x=1, RESTART_GAP=2, GAP=8, all in Q units);
  - the ADDR_BYTES legality check.
- One sub-module, sccb_qtimer: a reloadable quarter-period down-counter.
  - Inputs: load and a length in Q units.
  - Output: done, a one-cycle pulse.

## Test plan
- Write, addr=8'h12, wdata=8'h80, default parameters. Bus model decodes start, 42/ACK, 12/ACK, 80/ACK, stop. ready returns after exactly 7502 cycles.
- Read, addr=8'h0A, slave returns 8'h76. Bus model decodes 42, 0A, stop, restart, 43, 76, master NACK, stop. rdata=8'h76 and rdata_valid is a single pulse coincident with ready rising, at cycle 164*Q.
- ADDR_BYTES=2, write addr=16'h3008, wdata=8'h82. Bytes go out as 78, 30, 08, 82 (DEV_ADDR=8'h78). Duration is 157*Q cycles.
- Build with SCCB_NACK_CHECK_EN; slave NACKs the device address. nack=1, stop issued immediately after that byte, no data bytes sent. Build without the macro: full transfer completes and nack=0.
- reset pulsed mid-byte during a read. Next cycle: SIOC_oe=SIOD_oe=0, ready=1, nack=0. A following write completes normally.
- start pulsed while busy, plus back-to-back start held high. The busy pulse is ignored. The held start is accepted exactly on the first ready cycle.

Source files
------------

// File: rtl/sccb_pkg.sv
// sccb_pkg: shared FSM state type, phase lengths and parameter helpers for sccb_master.
// Contents:
//   state_t           FSM states of the master
//   LEN_*             phase lengths in quarter-bit (Q) units
//   addr_bytes_legal  legality check for the sub-address length
//   phase_len         length of a timed state in Q units
package sccb_pkg;

    typedef enum logic [3:0] {
        IDLE, START, BIT_LO, BIT_SET, BIT_HI, NEXT,
        STOP_1, STOP_2, STOP_3, STOP_4, GAP
    } state_t;

    localparam int LEN_START       = 1;
    localparam int LEN_BIT_LO      = 1;
    localparam int LEN_BIT_SET     = 1;
    localparam int LEN_BIT_HI      = 2;
    localparam int LEN_STOP        = 1;
    localparam int LEN_RESTART_GAP = 2;
    localparam int LEN_GAP         = 8;

    function automatic logic addr_bytes_legal(input int n);
        return n == 1 || n == 2;
    endfunction

    // final_gap selects the long closing gap over the short bus-free gap before a restart
    function automatic logic [3:0] phase_len(input state_t s, input logic final_gap);
        case (s)
            START:   return 4'(LEN_START);
            BIT_LO:  return 4'(LEN_BIT_LO);
            BIT_SET: return 4'(LEN_BIT_SET);
            BIT_HI:  return 4'(LEN_BIT_HI);
            GAP:     return final_gap ? 4'(LEN_GAP) : 4'(LEN_RESTART_GAP);
            default: return 4'(LEN_STOP);
        endcase
    endfunction

endpackage

// File: rtl/sccb_qtimer.sv
// sccb_qtimer: reloadable quarter-period down-counter timing each SCCB phase.
// Ports:
//   clk, reset  clock and synchronous active-high reset
//   load        first cycle of a new phase; restarts the count
//   len         phase length in Q units (1..8)
//   done        one-cycle pulse on the last clk of the phase
module sccb_qtimer #(
    parameter int Q = 62
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [3:0] len,
    output logic       done
);

    localparam int W = $clog2(8 * Q + 1);

    logic [W-1:0] cnt, reload, span;

    // load cycle is itself the first cycle of the phase, hence len*Q-2 remaining
    assign span = W'(int'(len) * Q - 2);
    assign done = !load && cnt == '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt    <= '0;
            reload <= '0;
        end else if (load) begin
            cnt    <= span;
            reload <= span + W'(1);
        end else begin
            cnt <= (cnt == '0) ? reload : cnt - W'(1);
        end
    end

endmodule

// File: rtl/sccb_master.sv
// sccb_master: SCCB/I2C-style register read/write master driving open-drain SIOC/SIOD.
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   start, rw, addr,      request (taken when ready=1); rw 0=write 1=read;
//   wdata                 addr/wdata latched at accept
//   SIOD_in               asynchronous SIOD pad readback
//   ready                 idle, able to accept start
//   rdata, rdata_valid    read result and its one-cycle completion pulse
//   nack                  ACK failure flag, cleared on accept
//   SIOC_oe, SIOD_oe      1 pulls the line low, 0 releases it
// Build option: define SCCB_NACK_CHECK_EN to check ACK slots and abort on NACK.
module sccb_master
    import sccb_pkg::*;
#(
    parameter int         CLK_FREQ   = 25000000,
    parameter int         SCCB_FREQ  = 100000,
    parameter logic [7:0] DEV_ADDR   = 8'h42,
    parameter int         ADDR_BYTES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        rw,
    input  logic [15:0] addr,
    input  logic [7:0]  wdata,
    input  logic        SIOD_in,
    output logic        ready,
    output logic [7:0]  rdata,
    output logic        rdata_valid,
    output logic        nack,
    output logic        SIOC_oe,
    output logic        SIOD_oe
);

    localparam int Q  = CLK_FREQ / (4 * SCCB_FREQ);
    localparam int AB = addr_bytes_legal(ADDR_BYTES) ? ADDR_BYTES : 1;

    state_t      state;
    logic [3:0]  bit_idx, len;
    logic [1:0]  byte_idx, last_byte;
    logic        phase, rw_q, nack_r, tload, done, s1, s2;
    logic        final_gap, rx_byte, tx_bit;
    logic [15:0] addr_q;
    logic [7:0]  wdata_q, rx, tx;

    // phase 0 carries the device address and sub-address (plus data on writes);
    // phase 1 is the repeated-start read of one byte
    assign final_gap = phase || !rw_q || nack_r;
    assign rx_byte   = phase && byte_idx == 2'd1;
    assign last_byte = phase ? 2'd1 : 2'(AB + (rw_q ? 0 : 1));
    // bit 8 is the ACK slot; received bytes transmit all ones, i.e. SIOD released
    assign tx_bit    = bit_idx[3] | tx[~bit_idx[2:0]];
    assign len       = phase_len(state, final_gap);
    assign nack      = nack_r;

    always_comb begin
        tx = 8'hFF;
        if (phase)
            tx = byte_idx == 2'd0 ? (DEV_ADDR | 8'h01) : 8'hFF;
        else
            case (byte_idx)
                2'd0:    tx = DEV_ADDR;
                2'd1:    tx = AB == 2 ? addr_q[15:8] : addr_q[7:0];
                2'd2:    tx = AB == 2 ? addr_q[7:0] : wdata_q;
                default: tx = wdata_q;
            endcase
    end

    sccb_qtimer #(.Q(Q)) u_qtimer (
        .clk   (clk),
        .reset (reset),
        .load  (tload),
        .len   (len),
        .done  (done)
    );

    always_ff @(posedge clk) begin
        s1 <= SIOD_in;
        s2 <= s1;
    end

    // Every transition registers the new line levels and pulses tload so the
    // timer restarts with the new state's length on the state's first cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            ready       <= 1'b1;
            SIOC_oe     <= 1'b0;
            SIOD_oe     <= 1'b0;
            rdata       <= 8'h00;
            rdata_valid <= 1'b0;
            nack_r      <= 1'b0;
            tload       <= 1'b0;
            bit_idx     <= 4'd0;
            byte_idx    <= 2'd0;
            phase       <= 1'b0;
            rw_q        <= 1'b0;
            addr_q      <= 16'h0000;
            wdata_q     <= 8'h00;
            rx          <= 8'h00;
        end else begin
            rdata_valid <= 1'b0;
            tload       <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    state    <= START;
                    ready    <= 1'b0;
                    SIOD_oe  <= 1'b1;
                    tload    <= 1'b1;
                    rw_q     <= rw;
                    addr_q   <= addr;
                    wdata_q  <= wdata;
                    nack_r   <= 1'b0;
                    phase    <= 1'b0;
                    byte_idx <= 2'd0;
                    bit_idx  <= 4'd0;
                end
                START: if (done) begin
                    state   <= BIT_LO;
                    SIOC_oe <= 1'b1;
                    tload   <= 1'b1;
                end
                BIT_LO: if (done) begin
                    state   <= BIT_SET;
                    SIOD_oe <= ~tx_bit;
                    tload   <= 1'b1;
                end
                BIT_SET: if (done) begin
                    state   <= BIT_HI;
                    SIOC_oe <= 1'b0;
                    tload   <= 1'b1;
                end
                // last clk of SCL high: sample, then advance bit/byte (the NEXT step)
                BIT_HI: if (done) begin
                    SIOC_oe <= 1'b1;
                    tload   <= 1'b1;
                    if (rx_byte && !bit_idx[3])
                        rx <= {rx[6:0], s2};
                    bit_idx <= bit_idx[3] ? 4'd0 : bit_idx + 4'd1;
                    if (bit_idx[3] && byte_idx != last_byte)
                        byte_idx <= byte_idx + 2'd1;
                    state <= (bit_idx[3] && byte_idx == last_byte) ? STOP_1 : BIT_LO;
`ifdef SCCB_NACK_CHECK_EN
                    if (bit_idx[3] && !rx_byte && s2) begin
                        nack_r <= 1'b1;
                        state  <= STOP_1;
                    end
`endif
                end
                STOP_1: if (done) begin
                    state   <= STOP_2;
                    SIOD_oe <= 1'b1;
                    tload   <= 1'b1;
                end
                STOP_2: if (done) begin
                    state   <= STOP_3;
                    SIOC_oe <= 1'b0;
                    tload   <= 1'b1;
                end
                STOP_3: if (done) begin
                    state   <= STOP_4;
                    SIOD_oe <= 1'b0;
                    tload   <= 1'b1;
                end
                STOP_4: if (done) begin
                    state <= GAP;
                    tload <= 1'b1;
                end
                GAP: if (done) begin
                    if (final_gap) begin
                        state       <= IDLE;
                        ready       <= 1'b1;
                        rdata_valid <= rw_q && !nack_r;
                        if (rw_q && !nack_r)
                            rdata <= rx;
                    end else begin
                        state    <= START;
                        phase    <= 1'b1;
                        byte_idx <= 2'd0;
                        bit_idx  <= 4'd0;
                        SIOD_oe  <= 1'b1;
                        tload    <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sccb_master.sv
// tb_sccb_master: directed bench for sccb_master with an SCCB bus decoder/slave model.
module tb_sccb_master;

    logic        clk = 1'b0, reset = 1'b1, start = 1'b0, start2 = 1'b0, rw = 1'b0;
    logic        sel = 1'b0, mdl_rst = 1'b0, nack_inj = 1'b0;
    logic [15:0] addr = 16'h0;
    logic [7:0]  wdata = 8'h0;
    logic        ready, rdata_valid, nack, sioc_oe, siod_oe;
    logic        ready2, rdata_valid2, nack2, sioc_oe2, siod_oe2;
    logic [7:0]  rdata, rdata2;
    logic        scl, sda, slave_low = 1'b0;

    int n_vec = 0, n_err = 0;
    int log_q[$];
    int exp_q[$];

    always #5 clk = ~clk;

    sccb_master u_dut (
        .clk(clk), .reset(reset), .start(start), .rw(rw), .addr(addr), .wdata(wdata),
        .SIOD_in(sda), .ready(ready), .rdata(rdata), .rdata_valid(rdata_valid),
        .nack(nack), .SIOC_oe(sioc_oe), .SIOD_oe(siod_oe)
    );

    sccb_master #(.DEV_ADDR(8'h78), .ADDR_BYTES(2)) u_dut2 (
        .clk(clk), .reset(reset), .start(start2), .rw(rw), .addr(addr), .wdata(wdata),
        .SIOD_in(sda), .ready(ready2), .rdata(rdata2), .rdata_valid(rdata_valid2),
        .nack(nack2), .SIOC_oe(sioc_oe2), .SIOD_oe(siod_oe2)
    );

    assign scl = !(sel ? sioc_oe2 : sioc_oe);
    assign sda = !(sel ? siod_oe2 : siod_oe) && !slave_low;

    // Bus model: tokens 'h400 start, 'h800 stop, {nack_bit, byte} per byte.
    // The slave ACKs written bytes and returns 8'h76 after a read address.
    logic       prev_scl = 1'b1, prev_sda = 1'b1, reading = 1'b0, first = 1'b0;
    logic [7:0] sh = 8'h0;
    logic [7:0] rd_byte = 8'h76;
    int         bitcnt = 0;

    always @(negedge clk) begin
        prev_scl <= scl;
        prev_sda <= sda;
        if (mdl_rst) begin
            slave_low <= 1'b0;
            reading   <= 1'b0;
            first     <= 1'b0;
            bitcnt    <= 0;
            log_q.delete();
        end else if (scl && prev_scl && prev_sda && !sda) begin
            log_q.push_back(32'h400);
            bitcnt  <= 0;
            first   <= 1'b1;
            reading <= 1'b0;
        end else if (scl && prev_scl && !prev_sda && sda) begin
            log_q.push_back(32'h800);
        end else if (scl && !prev_scl) begin
            if (bitcnt < 8) begin
                sh     <= {sh[6:0], sda};
                bitcnt <= bitcnt + 1;
            end else begin
                log_q.push_back({23'b0, sda, sh});
                bitcnt  <= 0;
                reading <= first && sh[0];
                first   <= 1'b0;
            end
        end else if (!scl && prev_scl) begin
            slave_low <= (bitcnt == 8) ? (!reading && !(first && nack_inj))
                                       : (reading && !rd_byte[7 - bitcnt]);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_log(input string tag);
        chk({tag, "_len"}, log_q.size(), exp_q.size());
        foreach (exp_q[i])
            if (i < log_q.size()) chk(tag, log_q[i], exp_q[i]);
    endtask

    task automatic clear_bus();
        @(negedge clk) mdl_rst = 1'b1;
        repeat (3) @(negedge clk);
        mdl_rst = 1'b0;
    endtask

    task automatic wait_ready(output int cyc, output int pulses, output logic rv_at_ready);
        cyc = 0;
        pulses = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
            if (sel ? rdata_valid2 : rdata_valid) pulses++;
        end while (!(sel ? ready2 : ready) && cyc < 20000);
        rv_at_ready = sel ? rdata_valid2 : rdata_valid;
        @(posedge clk);
        #1;
        if (sel ? rdata_valid2 : rdata_valid) pulses++;
    endtask

    task automatic xfer(input logic r, input logic [15:0] a, input logic [7:0] d,
                        output logic [2:0] acc, output int cyc, output int pulses,
                        output logic rv_at_ready);
        @(negedge clk);
        rw = r; addr = a; wdata = d;
        if (sel) start2 = 1'b1; else start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        start2 = 1'b0;
        acc = sel ? {ready2, sioc_oe2, siod_oe2} : {ready, sioc_oe, siod_oe};
        wait_ready(cyc, pulses, rv_at_ready);
    endtask

    initial begin
        logic [2:0] acc;
        int         cyc, pulses;
        logic       rv;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", ready, 1'b1);
        chk("rst_oe", {sioc_oe, siod_oe}, 2'b00);
        chk("rst_rdata", rdata, 8'h00);
        chk("rst_rv_nack", {rdata_valid, nack}, 2'b00);
        chk("rst_ready2", ready2, 1'b1);
        @(negedge clk) reset = 1'b0;
        clear_bus();

        // write 12 <- 80
        xfer(1'b0, 16'h0012, 8'h80, acc, cyc, pulses, rv);
        chk("wr_accept", acc, 3'b001);
        chk("wr_cycles", cyc, 7502);
        chk("wr_rv_pulses", pulses, 0);
        chk("wr_nack", nack, 1'b0);
        exp_q = {32'h400, 32'h042, 32'h012, 32'h080, 32'h800};
        chk_log("wr_bus");

        // read 0A -> 76
        clear_bus();
        xfer(1'b1, 16'h000A, 8'h00, acc, cyc, pulses, rv);
        chk("rd_cycles", cyc, 164 * 62);
        chk("rd_rv_at_ready", rv, 1'b1);
        chk("rd_rv_pulses", pulses, 1);
        chk("rd_rdata", rdata, 8'h76);
        exp_q = {32'h400, 32'h042, 32'h00A, 32'h800, 32'h400, 32'h043, 32'h176, 32'h800};
        chk_log("rd_bus");

        // two-byte sub-address instance
        clear_bus();
        sel = 1'b1;
        xfer(1'b0, 16'h3008, 8'h82, acc, cyc, pulses, rv);
        sel = 1'b0;
        chk("ab2_cycles", cyc, 157 * 62);
        exp_q = {32'h400, 32'h078, 32'h030, 32'h008, 32'h082, 32'h800};
        chk_log("ab2_bus");
        chk("rdata_hold", rdata, 8'h76);

        // slave NACKs the device address
        clear_bus();
        nack_inj = 1'b1;
        xfer(1'b0, 16'h0012, 8'h80, acc, cyc, pulses, rv);
        nack_inj = 1'b0;
`ifdef SCCB_NACK_CHECK_EN
        chk("nack_cycles", cyc, 49 * 62);
        chk("nack_flag", nack, 1'b1);
        exp_q = {32'h400, 32'h142, 32'h800};
`else
        chk("nack_cycles", cyc, 7502);
        chk("nack_flag", nack, 1'b0);
        exp_q = {32'h400, 32'h142, 32'h012, 32'h080, 32'h800};
`endif
        chk_log("nack_bus");
        chk("nack_rdata", rdata, 8'h76);

        // reset in the middle of bit 3 of the read device address (BIT_SET)
        clear_bus();
        @(negedge clk);
        rw = 1'b1; addr = 16'h000A; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (899) @(posedge clk);
        #1;
        chk("mid_oe_before", {sioc_oe, siod_oe}, 2'b11);
        @(negedge clk) reset = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_oe", {sioc_oe, siod_oe}, 2'b00);
        chk("mid_rst_ready_nack", {ready, nack}, 2'b10);
        @(negedge clk) reset = 1'b0;
        clear_bus();
        xfer(1'b0, 16'h0012, 8'h80, acc, cyc, pulses, rv);
        chk("post_rst_cycles", cyc, 7502);
        exp_q = {32'h400, 32'h042, 32'h012, 32'h080, 32'h800};
        chk_log("post_rst_bus");

        // busy start ignored; held start taken on the first ready cycle
        clear_bus();
        @(negedge clk);
        rw = 1'b0; addr = 16'h0012; wdata = 8'h80; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        cyc = 0;
        repeat (100) begin
            @(posedge clk);
            #1 cyc++;
        end
        @(negedge clk);
        addr = 16'h0055; start = 1'b1;
        @(posedge clk);
        #1 cyc++;
        start = 1'b0;
        chk("busy_ignored", ready, 1'b0);
        @(negedge clk);
        addr = 16'h0033; wdata = 8'h44; start = 1'b1;
        do begin
            @(posedge clk);
            #1 cyc++;
        end while (!ready && cyc < 20000);
        chk("busy_first_cycles", cyc, 7502);
        @(posedge clk);
        #1;
        chk("held_accept", {ready, siod_oe}, 2'b01);
        start = 1'b0;
        wait_ready(cyc, pulses, rv);
        chk("held_cycles", cyc, 7502);
        exp_q = {32'h400, 32'h042, 32'h012, 32'h080, 32'h800,
                 32'h400, 32'h042, 32'h033, 32'h044, 32'h800};
        chk_log("b2b_bus");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
